// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and hex encoding.
// Columns are driven active-low one at a time; rows are read active-low.
module keypad_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_N + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        row_s1;
  logic [3:0]        rs;
  logic [SLOT_W-1:0] slot_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [1:0]        col_idx;
  logic [1:0]        row_idx;
  logic              sample_pt;
  logic [3:0]        row_low;
  logic              one_low;
  logic [1:0]        hit_idx;
  logic              same_row;
  logic              deb_done;

  // Hex code for a key at (row, column) of the membrane matrix.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      row_s1 <= row;
      rs     <= row_s1;
    end
  end

  // Column slot timer; the last count of each slot is the sample point.
  always_ff @(posedge clk) begin
    if (rst || sample_pt) slot_cnt <= '0;
    else                  slot_cnt <= slot_cnt + SLOT_W'(1);
  end

  // Classify the synchronized rows: exactly one low row is a valid sample.
  always_comb begin
    sample_pt = (slot_cnt == SLOT_LAST);
    row_low   = ~rs;
    one_low   = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
    hit_idx   = 2'd0;
    case (row_low)
      4'b0010: hit_idx = 2'd1;
      4'b0100: hit_idx = 2'd2;
      4'b1000: hit_idx = 2'd3;
      default: hit_idx = 2'd0;
    endcase
    same_row = one_low && (hit_idx == row_idx);
    deb_done = ((deb_cnt + DEB_W'(1)) == DEB_LAST);
  end

  // Scan / debounce state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 4'b1110;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sample_pt) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              row_idx <= hit_idx;
              deb_cnt <= DEB_W'(1);
              state   <= DEB_PRESS;
            end else begin
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
            end
          end
          DEB_PRESS: begin
            if (same_row) begin
              deb_cnt <= deb_cnt + DEB_W'(1);
              if (deb_done) begin
                key       <= key_map(row_idx, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end
            end else begin
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end
          PRESSED: begin
            // A different single row in the held column is ignored.
            if (!one_low) begin
              deb_cnt <= DEB_W'(1);
              state   <= DEB_RELEASE;
            end
          end
          DEB_RELEASE: begin
            if (!one_low) begin
              deb_cnt <= deb_cnt + DEB_W'(1);
              if (deb_done) begin
                key_held <= 1'b0;
                col      <= {col[2:0], col[3]};
                col_idx  <= col_idx + 2'd1;
                state    <= SCAN;
              end
            end else if (same_row) begin
              state <= PRESSED;
            end else begin
              // Another row in the frozen column: still not a clean release.
              state <= PRESSED;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_N=3).
module tb_keypad_scan;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [3:0] pmask [4];
  int checks;
  int errors;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Membrane model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pmask[r] & ~col);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) pmask[r] = 4'h0;
  endtask

  // Reset with the last asserted edge called E0; returns 1 time unit after E0.
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] col_of(input int idx);
    logic [3:0] c;
    case (idx % 4)
      0: c = 4'b1110;
      1: c = 4'b1101;
      2: c = 4'b1011;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  task automatic test_reset();
    clear_keys();
    rst = 1'b1;
    tick(2);
    checks++;
    if (col !== 4'b1110 || key !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: col=%b key=%h valid=%b held=%b, want 1110 0 0 0", col, key, key_valid, key_held);
    end
  endtask

  task automatic test_idle_scan();
    int col_err;
    int vcnt;
    col_err = 0;
    vcnt = 0;
    clear_keys();
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      checks++;
      if (col !== col_of(k / 4)) begin
        errors++;
        col_err++;
        if (col_err < 4) $display("FAIL idle_col k=%0d: col=%b, want %b", k, col, col_of(k / 4));
      end
      if (key_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0 || key !== 4'h0) begin
      errors++;
      $display("FAIL idle_no_key: valid pulses=%0d key=%h, want 0 and 0", vcnt, key);
    end
  endtask

  task automatic test_press_5();
    int vcnt;
    vcnt = 0;
    clear_keys();
    rst = 1'b1;
    pmask[1] = 4'b0010;
    do_reset();
    tick(15);
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL press5_early: valid=%b held=%b at E15, want 0 0", key_valid, key_held);
    end
    tick(1);
    checks++;
    if (key_valid !== 1'b1 || key !== 4'h5 || key_held !== 1'b1 || col !== 4'b1101) begin
      errors++;
      $display("FAIL press5_accept: valid=%b key=%h held=%b col=%b, want 1 5 1 1101", key_valid, key, key_held, col);
    end
    tick(1);
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL press5_pulse_width: valid=%b held=%b, want 0 1", key_valid, key_held);
    end
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (key_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0 || col !== 4'b1101 || key_held !== 1'b1 || key !== 4'h5) begin
      errors++;
      $display("FAIL press5_hold: extra pulses=%0d col=%b held=%b key=%h, want 0 1101 1 5", vcnt, col, key_held, key);
    end
  endtask

  task automatic test_bounce();
    int vcnt;
    vcnt = 0;
    clear_keys();
    do_reset();
    tick(1);
    pmask[2] = 4'b0001;
    tick(4);
    pmask[2] = 4'b0000;
    if (key_valid === 1'b1) vcnt++;
    for (int k = 6; k <= 7; k++) begin
      tick(1);
      if (key_valid === 1'b1) vcnt++;
    end
    checks++;
    if (col !== 4'b1110) begin
      errors++;
      $display("FAIL bounce_freeze: col=%b at E7, want 1110", col);
    end
    tick(1);
    checks++;
    if (col !== 4'b1101) begin
      errors++;
      $display("FAIL bounce_advance: col=%b at E8, want 1101", col);
    end
    for (int k = 9; k <= 12; k++) begin
      tick(1);
      if (key_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0 || key !== 4'h0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL bounce_no_key: pulses=%0d key=%h held=%b, want 0 0 0", vcnt, key, key_held);
    end
  endtask

  task automatic test_hold_release();
    int vcnt;
    int waited;
    vcnt = 0;
    clear_keys();
    rst = 1'b1;
    pmask[3] = 4'b0100;
    do_reset();
    tick(20);
    checks++;
    if (key_valid !== 1'b1 || key !== 4'hF || key_held !== 1'b1 || col !== 4'b1011) begin
      errors++;
      $display("FAIL hash_accept: valid=%b key=%h held=%b col=%b, want 1 F 1 1011", key_valid, key, key_held, col);
    end
    for (int k = 21; k <= 60; k++) begin
      tick(1);
      if (key_valid === 1'b1) vcnt++;
    end
    pmask[3] = 4'b0000;
    for (int k = 61; k <= 71; k++) begin
      tick(1);
      if (key_valid === 1'b1) vcnt++;
    end
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL hash_held_before_release: held=%b at E71, want 1", key_held);
    end
    tick(1);
    if (key_valid === 1'b1) vcnt++;
    checks++;
    if (key_held !== 1'b0 || col !== 4'b0111 || key !== 4'hF) begin
      errors++;
      $display("FAIL hash_release: held=%b col=%b key=%h, want 0 0111 F", key_held, col, key);
    end
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL hash_single_pulse: extra pulses=%0d, want 0", vcnt);
    end
    pmask[3] = 4'b0100;
    waited = 0;
    while (key_valid !== 1'b1 && waited < 100) begin
      tick(1);
      waited++;
    end
    checks++;
    if (key_valid !== 1'b1 || key !== 4'hF) begin
      errors++;
      $display("FAIL hash_repress: valid=%b key=%h after %0d cycles, want 1 F", key_valid, key, waited);
    end
    pmask[3] = 4'b0000;
  endtask

  task automatic test_two_rows();
    int col_err;
    int vcnt;
    col_err = 0;
    vcnt = 0;
    clear_keys();
    rst = 1'b1;
    pmask[1] = 4'b0001;
    pmask[2] = 4'b0001;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (col !== col_of(k / 4)) col_err++;
      if (key_valid === 1'b1) vcnt++;
    end
    checks++;
    if (col_err != 0 || vcnt != 0 || key !== 4'h0) begin
      errors++;
      $display("FAIL two_rows_idle: col errors=%0d pulses=%0d key=%h, want 0 0 0", col_err, vcnt, key);
    end
    clear_keys();
  endtask

  task automatic test_reset_mid();
    int vcnt;
    vcnt = 0;
    clear_keys();
    rst = 1'b1;
    pmask[0] = 4'b0010;
    do_reset();
    tick(12);
    checks++;
    if (col !== 4'b1101 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL mid_deb_frozen: col=%b held=%b at E12, want 1101 0", col, key_held);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (col !== 4'b1110 || key !== 4'h0 || key_held !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_deb_press: col=%b key=%h held=%b valid=%b, want 1110 0 0 0", col, key, key_held, key_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (key_valid === 1'b1 || col !== 4'b1110) vcnt++;
    end
    rst = 1'b0;
    tick(15);
    if (key_valid === 1'b1) vcnt++;
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL rst_hold_quiet: violations=%0d, want 0", vcnt);
    end
    tick(1);
    checks++;
    if (key_valid !== 1'b1 || key !== 4'h2 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL redetect_after_rst: valid=%b key=%h held=%b at E16, want 1 2 1", key_valid, key, key_held);
    end
    tick(5);
    rst = 1'b1;
    tick(1);
    checks++;
    if (col !== 4'b1110 || key !== 4'h0 || key_held !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_pressed: col=%b key=%h held=%b valid=%b, want 1110 0 0 0", col, key, key_held, key_valid);
    end
    clear_keys();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int r = 0; r < 4; r++) pmask[r] = 4'h0;
    test_reset();
    test_idle_scan();
    test_press_5();
    test_bounce();
    test_hold_release();
    test_two_rows();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
